sv32_ptw: RTL and testbench
===========================

# sv32_ptw

Sv32 hardware page-table walker that refills the `cva6_tlb_sv32` TLB. It accepts a miss (virtual address plus ASID) and performs the one- or two-level Sv32 walk over a single-outstanding memory read port. It then either emits a one-cycle TLB update word in the exact `update_i` layout the TLB consumes, or raises a page-fault pulse. It sits between the MMU miss path and the data-side memory arbiter, on the write side of the TLB's update interface.

## Interface
- `ASID_WIDTH`, 9, width of ASID field carried into the update word
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `flush_i`  in  1  abort current walk (sfence.vma)
- `miss_valid_i`  in  1  miss request valid
- `miss_ready_o`  out  1  walker idle and able to accept a miss
- `miss_vaddr_i`  in  32  faulting virtual address
- `miss_asid_i`  in  ASID_WIDTH  ASID of request
- `satp_ppn_i`  in  22  root page-table PPN
- `mem_req_o`  out  1  read request
- `mem_addr_o`  out  34  physical PTE address
- `mem_gnt_i`  in  1  request accepted
- `mem_rvalid_i`  in  1  read data valid (exactly one per grant)
- `mem_rdata_i`  in  32  PTE
- `update_o`  out  63  {valid, is_4M, vpn[19:0], asid[8:0], pte[31:0]}; ASID zero-extended/truncated to 9 bits
- `page_fault_o`  out  1  one-cycle fault pulse
- `walk_active_o`  out  1  state ≠ IDLE

## Operation
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, EMIT, FAULT, DRAIN.
- IDLE: `miss_ready_o = !flush_i`. On `miss_valid_i && miss_ready_o`, latch vaddr/asid and go to L1_REQ.
- L1_REQ: `mem_req_o=1`, `mem_addr_o = {satp_ppn_i,12'b0} + vpn1*4`. On gnt go to L1_WAIT.
- L1_WAIT: on rvalid, decode the PTE:
  - V=0, or (R=0 && W=1): go to FAULT.
  - Leaf (R|X) with pte[19:10] ≠ 0 (misaligned superpage): go to FAULT.
  - Leaf otherwise: set is_4M=1 and go to EMIT.
  - Pointer: latch pte[31:10] and go to L0_REQ.
- L0_REQ: `mem_addr_o = {pte_ppn,12'b0} + vpn0*4` (34-bit arithmetic, no overflow possible).
- L0_WAIT: decode the PTE with the same rules; a non-leaf PTE at L0 goes to FAULT. A leaf sets is_4M=0 and goes to EMIT.
- EMIT: `update_o` valid for exactly 1 cycle, carrying the raw 32-bit PTE; then IDLE.
- FAULT: `page_fault_o` for exactly 1 cycle; `update_o[62]=0`; then IDLE.
- Flush behaviour:
  - In IDLE or EMIT/FAULT: no effect on the current output.
  - In *_REQ before gnt: drop the request and go to IDLE next cycle.
  - In *_REQ with gnt the same cycle, or in *_WAIT: go to DRAIN, discard the one pending rvalid, then IDLE. No update and no fault are produced for the aborted walk.
- A/D bits are not checked or written. Permission checks belong to the MMU.

## Timing
- Reset (async assert): state IDLE and all outputs 0, including `miss_ready_o`, `update_o`, `mem_addr_o`, `page_fault_o`, `walk_active_o`. Reset deassertion gives IDLE with ready=1 the next edge.
- Reset mid-walk: immediate IDLE. A later stray rvalid is ignored in IDLE.
- `mem_req_o` and `mem_addr_o` are registered and held stable until gnt.
- Best-case latency, accept in cycle N:
  - 4M leaf: req N+1, gnt N+1, rvalid N+2, update N+3.
  - 4K leaf: update N+5.
- `miss_ready_o` is high again the cycle after EMIT/FAULT. Back-to-back misses are therefore separated by one IDLE cycle.
- A `miss_valid_i` asserted together with `flush_i` in IDLE is not accepted.

## Structure
- `sv32_ptw_pkg` holds:
  - `pte_t` packed struct: ppn1[11:0], ppn0[9:0], rsw, D, A, G, U, X, W, R, V.
  - `ptw_state_e`.
  - `UPDATE_W=63`, `PAGE_SHIFT=12`, `PTE_SIZE=4`.
  - `tlb_update_t`, matching the TLB update layout.
- Sub-module `sv32_pte_decode`: combinational; inputs pte and level; outputs is_leaf, is_fault. Used by both WAIT states.

## Test plan
- 4K walk: satp_ppn=0x00080, vaddr=0x40001000, asid=1. L1 read at 0x000080400 returns 0x00020001; L0 read at 0x000080004 returns 0x2000000F. Required: update_o={1,0,0x40001,9'd1,0x2000000F} for one cycle, then ready=1.
- 4M leaf: L1 returns 0x2000000F. Required: is_4M=1, a single memory read, update at N+3 with zero-wait grant.
- Faults, each giving page_fault_o=1 for one cycle, no update, and no further memory request:
  - misaligned superpage 0x2000040F;
  - V=0 PTE 0x00000000;
  - W-without-R 0x00000005.
- Flush in L1_WAIT: rvalid arrives 3 cycles later. Required: no update, no fault, ready=1 only after that rvalid. Flush in L1_REQ with gnt held low: req drops next cycle.
- Grant stall: gnt held low for 5 cycles. Required: mem_addr_o stable and req continuously high; same final update as the 4K walk.
- Reset asserted in L0_WAIT: all outputs 0 asynchronously; a late rvalid after deassertion produces no update.

Source files
------------

// File: rtl/sv32_ptw_pkg.sv
// Shared types, constants and PTE address helper for the Sv32 page-table walker.
// tlb_update_t field order mirrors the TLB update port, MSB first.
package sv32_ptw_pkg;

  localparam int UPDATE_W   = 63;
  localparam int PAGE_SHIFT = 12;
  localparam int PTE_SIZE   = 4;
  localparam int PADDR_W    = 34;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1_REQ,
    ST_L1_WAIT,
    ST_L0_REQ,
    ST_L0_WAIT,
    ST_EMIT,
    ST_FAULT,
    ST_DRAIN
  } ptw_state_e;

  typedef struct packed {
    logic        valid;
    logic        is_4m;
    logic [19:0] vpn;
    logic [8:0]  asid;
    logic [31:0] pte;
  } tlb_update_t;

  // Page base plus VPN slot offset; the low 12 bits of the base are zero, so no carry out.
  function automatic logic [PADDR_W-1:0] pte_addr(input logic [21:0] ppn, input logic [9:0] vpn);
    pte_addr = ({12'b0, ppn} << PAGE_SHIFT) + PADDR_W'(vpn) * PADDR_W'(PTE_SIZE);
  endfunction

endpackage

// File: rtl/sv32_pte_decode.sv
// Combinational Sv32 PTE classifier (leaf / fault) for either walk level; zero latency.
// No handshake: consumed in the same cycle the PTE arrives.
module sv32_pte_decode
  import sv32_ptw_pkg::*;
(
  input  pte_t i_pte,
  input  logic i_level,
  output logic o_is_leaf,
  output logic o_is_fault
);

  logic w_leaf;
  logic w_unused;

  assign w_leaf    = i_pte.r | i_pte.x;
  assign o_is_leaf = w_leaf;
  assign w_unused  = ^{i_pte.ppn1, i_pte.rsw, i_pte.d, i_pte.a, i_pte.g, i_pte.u};

  // Level 1 leaves must be 4 MiB aligned; level 0 has no further table to point at.
  always_comb begin
    o_is_fault = 1'b0;
    if (!i_pte.v || (!i_pte.r && i_pte.w)) begin
      o_is_fault = 1'b1;
    end else if (i_level && w_leaf && (i_pte.ppn0 != '0)) begin
      o_is_fault = 1'b1;
    end else if (!i_level && !w_leaf) begin
      o_is_fault = 1'b1;
    end
  end

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 walker: miss in, one/two PTE reads, TLB update or fault pulse out (4M: N+3, 4K: N+5).
// Single outstanding read; request held until grant; miss_ready_o low for the whole walk.
module sv32_ptw
  import sv32_ptw_pkg::*;
#(
  parameter int ASID_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [31:0]           miss_vaddr_i,
  input  logic [ASID_WIDTH-1:0] miss_asid_i,
  input  logic [21:0]           satp_ppn_i,
  output logic                  mem_req_o,
  output logic [PADDR_W-1:0]    mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [UPDATE_W-1:0]   update_o,
  output logic                  page_fault_o,
  output logic                  walk_active_o
);

  ptw_state_e         r_state;
  ptw_state_e         w_next_state;
  logic               r_alive;
  logic               r_mem_req;
  logic [PADDR_W-1:0] r_mem_addr;
  logic               r_is_4m;
  logic [19:0]        r_vpn;
  logic [8:0]         r_asid;
  logic [31:0]        r_pte;

  pte_t        w_pte;
  logic        w_level;
  logic        w_is_leaf;
  logic        w_is_fault;
  logic        w_accept;
  logic        w_unused_vaddr;
  tlb_update_t w_upd;

  assign w_pte          = pte_t'(mem_rdata_i);
  assign w_level        = (r_state == ST_L1_WAIT);
  assign w_unused_vaddr = ^miss_vaddr_i[11:0];

  sv32_pte_decode u_decode (
    .i_pte      (w_pte),
    .i_level    (w_level),
    .o_is_leaf  (w_is_leaf),
    .o_is_fault (w_is_fault)
  );

  // r_alive keeps ready low while reset is held and for the first edge after release.
  assign miss_ready_o = (r_state == ST_IDLE) && r_alive && !flush_i;
  assign w_accept     = miss_valid_i && miss_ready_o;
  assign mem_req_o    = r_mem_req;
  assign mem_addr_o   = r_mem_addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_upd         = '0;
    page_fault_o  = 1'b0;
    walk_active_o = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_L1_REQ;
      end
      ST_L1_REQ, ST_L0_REQ: begin
        if (mem_gnt_i) begin
          if (flush_i)                    w_next_state = ST_DRAIN;
          else if (r_state == ST_L1_REQ)  w_next_state = ST_L1_WAIT;
          else                            w_next_state = ST_L0_WAIT;
        end else if (flush_i) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_L1_WAIT, ST_L0_WAIT: begin
        // A flush coinciding with the response has nothing left to drain.
        if (mem_rvalid_i) begin
          if (flush_i)         w_next_state = ST_IDLE;
          else if (w_is_fault) w_next_state = ST_FAULT;
          else if (w_is_leaf)  w_next_state = ST_EMIT;
          else                 w_next_state = ST_L0_REQ;
        end else if (flush_i) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_EMIT: begin
        w_upd.valid  = 1'b1;
        w_upd.is_4m  = r_is_4m;
        w_upd.vpn    = r_vpn;
        w_upd.asid   = r_asid;
        w_upd.pte    = r_pte;
        w_next_state = ST_IDLE;
      end
      ST_FAULT: begin
        page_fault_o = 1'b1;
        w_next_state = ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_rvalid_i) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    update_o = w_upd;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alive    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_is_4m    <= 1'b0;
      r_vpn      <= '0;
      r_asid     <= '0;
      r_pte      <= '0;
    end else begin
      r_alive   <= 1'b1;
      r_mem_req <= (w_next_state == ST_L1_REQ) || (w_next_state == ST_L0_REQ);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_vpn      <= miss_vaddr_i[31:12];
            r_asid     <= 9'(miss_asid_i);
            r_mem_addr <= pte_addr(satp_ppn_i, miss_vaddr_i[31:22]);
          end
        end
        ST_L1_WAIT, ST_L0_WAIT: begin
          if (mem_rvalid_i && !flush_i) begin
            r_pte   <= mem_rdata_i;
            r_is_4m <= (r_state == ST_L1_WAIT);
            if (w_next_state == ST_L0_REQ) begin
              r_mem_addr <= pte_addr(mem_rdata_i[31:10], r_vpn[9:0]);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sv32_ptw.sv
// Self-checking bench for sv32_ptw: directed walks, flush/reset cases and random walks
// compared against a spec-level walk model over a sparse memory image.
module tb_sv32_ptw;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        miss_valid;
  logic        miss_ready_o;
  logic [31:0] miss_vaddr;
  logic [8:0]  miss_asid;
  logic [21:0] satp;
  logic        mem_req_o;
  logic [33:0] mem_addr_o;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [62:0] update_o;
  logic        page_fault_o;
  logic        walk_active_o;

  int tests = 0;
  int fails = 0;
  bit seen_upd;
  bit seen_flt;

  logic [31:0] mem [logic [33:0]];

  sv32_ptw #(.ASID_WIDTH(9)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .miss_valid_i  (miss_valid),
    .miss_ready_o  (miss_ready_o),
    .miss_vaddr_i  (miss_vaddr),
    .miss_asid_i   (miss_asid),
    .satp_ppn_i    (satp),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .update_o      (update_o),
    .page_fault_o  (page_fault_o),
    .walk_active_o (walk_active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (update_o[62]) seen_upd = 1'b1;
    if (page_fault_o) seen_flt = 1'b1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [33:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [33:0] slot(input logic [21:0] ppn, input logic [9:0] idx);
    return ({12'h0, ppn} << 12) + 34'(idx) * 34'd4;
  endfunction

  // Sv32 walk as written in the architecture: root table, optional second level.
  function automatic void model(input logic [21:0] s, input logic [31:0] va, input logic [8:0] asid,
                                output bit flt, output logic [62:0] upd, output int nr,
                                output logic [33:0] a1, output logic [33:0] a2);
    logic [31:0] p;
    bit v, r, w, x;
    flt = 1'b0;
    upd = '0;
    a2  = '0;
    a1  = slot(s, va[31:22]);
    p   = mem_rd(a1);
    nr  = 1;
    {x, w, r, v} = p[3:0];
    if (!v || (w && !r)) begin
      flt = 1'b1;
    end else if (r || x) begin
      if (p[19:10] != 10'h0) flt = 1'b1;
      else upd = {1'b1, 1'b1, va[31:12], asid, p};
    end else begin
      a2 = slot(p[31:10], va[21:12]);
      p  = mem_rd(a2);
      nr = 2;
      {x, w, r, v} = p[3:0];
      if (!v || (w && !r) || !(r || x)) flt = 1'b1;
      else upd = {1'b1, 1'b0, va[31:12], asid, p};
    end
  endfunction

  function automatic logic [31:0] rand_pte(input int kind);
    logic [31:0] p;
    p = $urandom();
    case (kind)
      0: p[3:0] = 4'b0001;
      1: begin
        p[0] = 1'b1;
        if (!p[1]) p[3:1] = 3'b100;
        p[19:10] = 10'h0;
      end
      2: begin
        p[1:0] = 2'b11;
        p[10]  = 1'b1;
      end
      3: p[0] = 1'b0;
      default: p[2:0] = 3'b101;
    endcase
    return p;
  endfunction

  // Issues one miss, plays the memory side, and checks result, reads, latency and req stability.
  task automatic do_walk(input string tag, input logic [21:0] s, input logic [31:0] va,
                         input logic [8:0] asid, input int stall, input int rlat,
                         output logic [62:0] o_upd, output bit o_flt);
    bit          eflt;
    logic [62:0] eupd;
    int          enr;
    logic [33:0] ea1, ea2, ea;
    logic [33:0] got_a[$];
    logic [33:0] pend_addr, hold_addr;
    logic [63:0] obs;
    int          stall_cnt, rv_cnt, done_cyc, unstable;
    bit          got_flt;
    logic [62:0] got_upd;

    model(s, va, asid, eflt, eupd, enr, ea1, ea2);
    got_a.delete();
    stall_cnt = 0;
    rv_cnt    = 0;
    done_cyc  = 0;
    unstable  = 0;
    got_flt   = 1'b0;
    got_upd   = '0;
    pend_addr = '0;
    hold_addr = '0;

    satp       = s;
    miss_vaddr = va;
    miss_asid  = asid;
    miss_valid = 1'b1;
    #1;
    chk({tag, "_ready_in"}, miss_ready_o, 1);
    @(negedge clk);
    miss_valid = 1'b0;

    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      if (update_o[62]) begin
        got_upd  = update_o;
        done_cyc = cyc;
      end
      if (page_fault_o) begin
        got_flt  = 1'b1;
        done_cyc = cyc;
      end
      mem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_rd(pend_addr);
        end
      end
      mem_gnt = 1'b0;
      if (mem_req_o) begin
        if (stall_cnt > 0 && mem_addr_o !== hold_addr) unstable++;
        hold_addr = mem_addr_o;
        if (stall_cnt == stall) begin
          mem_gnt   = 1'b1;
          got_a.push_back(mem_addr_o);
          pend_addr = mem_addr_o;
          rv_cnt    = rlat;
          stall_cnt = 0;
        end else begin
          stall_cnt++;
        end
      end else if (stall_cnt != 0) begin
        unstable++;
      end
      @(negedge clk);
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;

    chk({tag, "_done"}, done_cyc != 0, 1);
    chk({tag, "_update"}, got_upd, eflt ? 63'h0 : eupd);
    chk({tag, "_fault"}, got_flt, eflt);
    chk({tag, "_nreads"}, got_a.size(), enr);
    for (int i = 0; i < enr; i++) begin
      ea  = (i == 0) ? ea1 : ea2;
      obs = (i < got_a.size()) ? 64'(got_a[i]) : 64'hDEAD_DEAD_DEAD_DEAD;
      chk($sformatf("%s_addr%0d", tag, i), obs, 64'(ea));
    end
    chk({tag, "_req_stable"}, unstable, 0);
    if (stall == 0 && rlat == 1) chk({tag, "_latency"}, done_cyc, (enr == 1) ? 3 : 5);
    chk({tag, "_ready_after"}, miss_ready_o, 1);
    chk({tag, "_upd_1cyc"}, update_o, 63'h0);
    chk({tag, "_flt_1cyc"}, page_fault_o, 0);
    o_upd = got_upd;
    o_flt = got_flt;
  endtask

  logic [62:0] r_upd;
  bit          r_flt;
  logic [31:0] fault_ptes [3];
  logic [31:0] rva, p1;
  logic [21:0] rsatp;
  logic [33:0] ra1;

  initial begin
    rst = 1'b1; flush = 1'b0; miss_valid = 1'b0; miss_vaddr = '0; miss_asid = '0;
    satp = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    seen_upd = 1'b0; seen_flt = 1'b0;
    fault_ptes[0] = 32'h2000040F;
    fault_ptes[1] = 32'h00000000;
    fault_ptes[2] = 32'h00000005;

    // Reset state
    #12;
    chk("rst_ready", miss_ready_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_update", update_o, 0);
    chk("rst_fault", page_fault_o, 0);
    chk("rst_active", walk_active_o, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", miss_ready_o, 1);

    // Miss together with flush in IDLE is refused
    miss_valid = 1'b1; flush = 1'b1; miss_vaddr = 32'h4000_1000; satp = 22'h80;
    #1; chk("idle_flush_ready", miss_ready_o, 0);
    @(negedge clk); miss_valid = 1'b0; flush = 1'b0;
    #1; chk("idle_flush_active", walk_active_o, 0);
    chk("idle_flush_req", mem_req_o, 0);
    @(negedge clk);

    // 4K walk
    mem.delete();
    mem[34'h0_0008_0400] = 32'h00020001;
    mem[34'h0_0008_0004] = 32'h2000000F;
    do_walk("w4k", 22'h80, 32'h4000_1000, 9'd1, 0, 1, r_upd, r_flt);
    chk("w4k_word", r_upd, {1'b1, 1'b0, 20'h40001, 9'd1, 32'h2000000F});

    // Same walk with a 5-cycle grant stall on each read
    do_walk("stall", 22'h80, 32'h4000_1000, 9'd1, 5, 1, r_upd, r_flt);
    chk("stall_word", r_upd, {1'b1, 1'b0, 20'h40001, 9'd1, 32'h2000000F});

    // 4M leaf
    mem.delete();
    mem[34'h0_0008_0400] = 32'h2000000F;
    do_walk("w4m", 22'h80, 32'h4000_1000, 9'd1, 0, 1, r_upd, r_flt);
    chk("w4m_word", r_upd, {1'b1, 1'b1, 20'h40001, 9'd1, 32'h2000000F});

    // Level-1 faults
    for (int i = 0; i < 3; i++) begin
      mem.delete();
      mem[34'h0_0008_0400] = fault_ptes[i];
      do_walk($sformatf("flt%0d", i), 22'h80, 32'h4000_1000, 9'd1, 0, 1, r_upd, r_flt);
      chk($sformatf("flt%0d_pulse", i), r_flt, 1);
    end

    // Flush in L1_WAIT; response turns up three cycles later
    mem.delete();
    seen_upd = 1'b0; seen_flt = 1'b0;
    satp = 22'h80; miss_vaddr = 32'h4000_1000; miss_asid = 9'd3; miss_valid = 1'b1;
    step(); miss_valid = 1'b0;
    chk("fw_req", mem_req_o, 1);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    #1; chk("fw_ready_d1", miss_ready_o, 0);
    chk("fw_active_d1", walk_active_o, 1);
    step(); #1; chk("fw_ready_d2", miss_ready_o, 0);
    step(); #1; chk("fw_ready_d3", miss_ready_o, 0);
    chk("fw_req_d3", mem_req_o, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h2000000F;
    step(); mem_rvalid = 1'b0;
    #1; chk("fw_ready_after", miss_ready_o, 1);
    step();
    chk("fw_no_update", seen_upd, 0);
    chk("fw_no_fault", seen_flt, 0);

    // Flush in L1_REQ with grant held low
    seen_upd = 1'b0; seen_flt = 1'b0;
    miss_valid = 1'b1;
    step(); miss_valid = 1'b0;
    chk("fr_req", mem_req_o, 1);
    flush = 1'b1; step(); flush = 1'b0;
    #1; chk("fr_req_drop", mem_req_o, 0);
    chk("fr_active", walk_active_o, 0);
    chk("fr_ready", miss_ready_o, 1);
    chk("fr_no_update", seen_upd, 0);
    chk("fr_no_fault", seen_flt, 0);
    step();

    // Reset while in L0_WAIT
    seen_upd = 1'b0; seen_flt = 1'b0;
    miss_valid = 1'b1;
    step(); miss_valid = 1'b0;
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h00020001; step(); mem_rvalid = 1'b0;
    chk("rw_l0_req", mem_req_o, 1);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    chk("rw_active", walk_active_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rw_req", mem_req_o, 0);
    chk("rw_addr", mem_addr_o, 0);
    chk("rw_update", update_o, 0);
    chk("rw_fault", page_fault_o, 0);
    chk("rw_active0", walk_active_o, 0);
    chk("rw_ready", miss_ready_o, 0);
    step(); rst = 1'b0;
    step();
    chk("rw_ready_rel", miss_ready_o, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'h2000000F; step(); mem_rvalid = 1'b0;
    step(); step();
    chk("rw_stray_update", seen_upd, 0);
    chk("rw_stray_active", walk_active_o, 0);

    // Random walks
    for (int n = 0; n < 40; n++) begin
      int k1;
      mem.delete();
      rva   = $urandom();
      rsatp = 22'($urandom());
      k1    = $urandom_range(0, 7);
      if (k1 > 4) k1 = 0;
      ra1 = slot(rsatp, rva[31:22]);
      p1  = rand_pte(k1);
      mem[ra1] = p1;
      if (k1 == 0) mem[slot(p1[31:10], rva[21:12])] = rand_pte($urandom_range(0, 4));
      do_walk($sformatf("rnd%0d", n), rsatp, rva, 9'($urandom()),
              $urandom_range(0, 3), $urandom_range(1, 3), r_upd, r_flt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
